ser_tx: RTL
===========

Name: ser_tx

Overview:
- Parallel-to-serial transmitter: the sending end of the team's bit-serial framed link. The matching deserializer lives on the receive side.
- Accepts one WIDTH-bit word per valid/ready handshake and shifts it out LSB first on a single serial line, with a frame strobe and an optional even-parity bit.
- Sits between a core datapath and an outgoing serial pin or lane.

Parameters:
- WIDTH, 8: data word width. WIDTH == 0 must fail elaboration.
- PARITY, 1: 1 appends one even-parity bit per frame; 0 omits it.
- IDLE_BITS, 1: number of guard cycles (0..15) after each frame, with ser_o = 1 and frame_o = 0.

Ports:
- clk_i  input  1  clock, rising edge.
- rstn_i  input  1  reset, asynchronous, active-low.
- data_i  input  WIDTH  parallel word to send.
- valid_i  input  1  data_i is valid.
- ready_o  output  1  transmitter can accept a word.
- ser_o  output  1  serial data out. Idle level is 1.
- frame_o  output  1  high while ser_o carries a data or parity bit.
- busy_o  output  1  high whenever the state is not IDLE.

Behaviour:
- One clock domain. Reset is asynchronous and active-low: clk_i and rstn_i only.
- All outputs are registered and driven directly from state/shift registers. No combinational paths from input to output.
- Reset (rstn_i low, asynchronous) values: state = IDLE, ready_o = 1, ser_o = 1, frame_o = 0, busy_o = 0. Shift register and bit counter cleared.
- FSM states: IDLE, DATA, PAR, GAP.
- IDLE:
  - ready_o = 1.
  - On an edge with valid_i && ready_o: capture data_i into the shift register, compute parity = XOR of all data_i bits, clear the bit counter, go to DATA.
- DATA:
  - ser_o = shift[0], frame_o = 1.
  - Each edge: shift right and increment the counter.
  - After WIDTH cycles: go to PAR if PARITY = 1; else to GAP if IDLE_BITS > 0; else to IDLE.
- PAR:
  - One cycle, ser_o = parity bit, frame_o = 1.
  - Even parity: total number of 1s across data plus parity is even.
  - Next state: GAP if IDLE_BITS > 0, else IDLE.
- GAP:
  - IDLE_BITS cycles, ser_o = 1, frame_o = 0. Then IDLE.
- Latency: the first data bit appears on ser_o in the cycle after the accepting edge.
- Throughput: minimum accept-to-accept interval = WIDTH + PARITY + IDLE_BITS + 1 cycles. The IDLE cycle is mandatory and is where ready_o is high.
- ready_o = 0 in DATA, PAR and GAP. valid_i and data_i are ignored in those states; changes to data_i after acceptance have no effect.
- Counter width is clog2(WIDTH + 1) bits. Gap counter is 4 bits. No wrap-around beyond the terminal count.
- busy_o = 1 in DATA, PAR and GAP.
- Reset asserted mid-frame: outputs return to reset values immediately (asynchronously). The in-flight word is discarded and never resumed. The first edge after release sees IDLE with ready_o = 1.
- valid_i held high continuously: a new word is accepted at each IDLE cycle, giving back-to-back frames at the minimum interval.

Test Plan:
- WIDTH=8, PARITY=1, IDLE_BITS=2; send 0xA5 -> ser_o = 1,0,1,0,0,1,0,1 then parity 0. frame_o high for exactly 9 cycles, then 2 cycles of ser_o = 1 with frame_o = 0, then ready_o = 1.
- Same configuration; send 0x07 -> data bits 1,1,1,0,0,0,0,0, parity bit 1.
- valid_i held high with words 0x11 then 0x22 -> accepts exactly 12 cycles apart. ready_o is high for 1 cycle per frame. Second frame carries 0x22.
- Toggle valid_i and data_i during a frame (e.g. drive 0xFF mid-frame) -> no acceptance, and the ongoing frame's bits are unchanged.
- Assert rstn_i low between clock edges during data bit 4 -> ser_o = 1, frame_o = 0, busy_o = 0 and ready_o = 1 immediately. After release, a new word 0x3C transmits completely and correctly.
- PARITY=0, IDLE_BITS=0, WIDTH=4; continuous valid_i with 0x9 -> ser_o = 1,0,0,1 every 5 cycles. frame_o is low only in the IDLE cycle. No parity bit is sent.

Source files
------------

// File: rtl/ser_tx.sv
// ser_tx: parallel-to-serial framed transmitter, LSB first, with an
// optional even-parity bit and idle guard cycles after each frame.
module ser_tx #(
    parameter int WIDTH     = 8,
    parameter int PARITY    = 1,
    parameter int IDLE_BITS = 1
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             ser_o,
    output logic             frame_o,
    output logic             busy_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [3:0] GAP_LAST =
        (IDLE_BITS > 0) ? 4'(IDLE_BITS - 1) : 4'd0;

    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("ser_tx: WIDTH must be at least 1");
        end
        if (PARITY != 0 && PARITY != 1) begin : g_bad_parity
            $error("ser_tx: PARITY must be 0 or 1");
        end
        if (IDLE_BITS < 0 || IDLE_BITS > 15) begin : g_bad_idle
            $error("ser_tx: IDLE_BITS must be in 0..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PAR,
        GAP
    } state_t;

    state_t         state;
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] shift_nxt;
    logic [CW-1:0]  cnt;
    logic [3:0]     gcnt;
    logic           par;

    assign shift_nxt = shift >> 1;

    // Outputs are loaded with the value of the state being entered,
    // so every output is a plain flop.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state   <= IDLE;
            shift   <= '0;
            cnt     <= '0;
            gcnt    <= '0;
            par     <= 1'b0;
            ready_o <= 1'b1;
            ser_o   <= 1'b1;
            frame_o <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (valid_i && ready_o) begin
                        shift   <= data_i;
                        par     <= ^data_i;
                        cnt     <= '0;
                        state   <= DATA;
                        ready_o <= 1'b0;
                        busy_o  <= 1'b1;
                        ser_o   <= data_i[0];
                        frame_o <= 1'b1;
                    end
                end
                DATA: begin
                    shift <= shift_nxt;
                    if (cnt == CNT_LAST) begin
                        if (PARITY != 0) begin
                            state <= PAR;
                            ser_o <= par;
                        end else if (IDLE_BITS > 0) begin
                            state   <= GAP;
                            gcnt    <= '0;
                            ser_o   <= 1'b1;
                            frame_o <= 1'b0;
                        end else begin
                            state   <= IDLE;
                            ready_o <= 1'b1;
                            busy_o  <= 1'b0;
                            ser_o   <= 1'b1;
                            frame_o <= 1'b0;
                        end
                    end else begin
                        cnt   <= cnt + 1'b1;
                        ser_o <= shift_nxt[0];
                    end
                end
                PAR: begin
                    ser_o   <= 1'b1;
                    frame_o <= 1'b0;
                    if (IDLE_BITS > 0) begin
                        state <= GAP;
                        gcnt  <= '0;
                    end else begin
                        state   <= IDLE;
                        ready_o <= 1'b1;
                        busy_o  <= 1'b0;
                    end
                end
                GAP: begin
                    if (gcnt == GAP_LAST) begin
                        state   <= IDLE;
                        ready_o <= 1'b1;
                        busy_o  <= 1'b0;
                    end else begin
                        gcnt <= gcnt + 4'd1;
                    end
                end
            endcase
        end
    end

endmodule
